// File: rtl/retire_rat.sv
// Retirement RAT: holds the committed arch->phys map and returns each superseded preg to the free list in commit order.
// Latency: map update visible after the accepting edge; freed tag is offered on fl_enqueue one cycle later (no bypass).
// Backpressure: commit_ready drops while the release buffer is full (registered only); releases stall while fl_full is high.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   commit_valid/ready/rd/pd   ROB commit handshake with destination arch reg and its new preg
//   fl_full                    free list cannot take a tag this cycle
//   fl_enqueue, fl_preg_out    push of one freed preg into the free list
//   rrf_map                    flattened committed map, entry i at [i*PHYS_WIDTH +: PHYS_WIDTH]
//   rel_count                  release buffer occupancy
module retire_rat #(
   parameter int ARCH_REGS  = 32,
   parameter int PHYS_WIDTH = 6,
   parameter int REL_DEPTH  = 2
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              commit_valid,
   output logic                              commit_ready,
   input  logic [4:0]                        commit_rd,
   input  logic [PHYS_WIDTH-1:0]             commit_pd,
   input  logic                              fl_full,
   output logic                              fl_enqueue,
   output logic [PHYS_WIDTH-1:0]             fl_preg_out,
   output logic [ARCH_REGS*PHYS_WIDTH-1:0]   rrf_map,
   output logic [$clog2(REL_DEPTH):0]        rel_count
);

   localparam int IDX_W = $clog2(REL_DEPTH);
   localparam int PTR_W = IDX_W + 1;

   logic [PHYS_WIDTH-1:0] map_q [ARCH_REGS];
   logic [PHYS_WIDTH-1:0] rel_q [REL_DEPTH];
   logic [PTR_W-1:0]      head_q, head_d;
   logic [PTR_W-1:0]      tail_q, tail_d;

   logic rel_empty, rel_full;
   logic commit_acc, commit_wr;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign rel_empty = (head_q == tail_q);
   assign rel_full  = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]) &&
                      (head_q[IDX_W] != tail_q[IDX_W]);
   assign rel_count = tail_q - head_q;

   // Ready comes purely from registered occupancy; fl_full never reaches it combinationally.
   assign commit_ready = !rel_full;
   assign commit_acc   = commit_valid && commit_ready;
   // x0 commits are consumed but never remap or free anything.
   assign commit_wr    = commit_acc && (commit_rd != 5'd0);

   assign fl_enqueue  = !rel_empty && !fl_full;
   assign fl_preg_out = fl_enqueue ? rel_q[head_q[IDX_W-1:0]] : '0;

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      if (fl_enqueue) head_d = head_q + PTR_W'(1);
      if (commit_wr)  tail_d = tail_q + PTR_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q <= '0;
         tail_q <= '0;
         for (int i = 0; i < ARCH_REGS; i++) map_q[i] <= PHYS_WIDTH'(i);
         for (int j = 0; j < REL_DEPTH; j++) rel_q[j] <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         if (commit_wr) begin
            // Old mapping is read before this edge's write, so back-to-back
            // commits to one rd release the earlier commit's preg.
            rel_q[tail_q[IDX_W-1:0]] <= map_q[commit_rd];
            map_q[commit_rd]         <= commit_pd;
         end
      end
   end

   for (genvar g = 0; g < ARCH_REGS; g++) begin : g_map_out
      assign rrf_map[g*PHYS_WIDTH +: PHYS_WIDTH] = map_q[g];
   end

endmodule
